// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, trap causes,
// FSM states and the request legality checks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic is_illegal(input logic load, input logic store,
                                        input logic [2:0] funct3);
        logic load_ok;
        logic store_ok;
        load_ok  = 1'b0;
        store_ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: begin
                load_ok  = 1'b1;
                store_ok = 1'b1;
            end
            F3_BU, F3_HU: load_ok = 1'b1;
            default: ;
        endcase
        return (load == store) | (store & ~store_ok) | (load & ~load_ok);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = |addr_lo;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask and data replication on the way out,
// lane selection and sign/zero extension of read data on the way back.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        mask      = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (funct3)
            F3_B, F3_BU: begin
                mask      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                mask      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = funct3[2] ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory stage: decodes and traps bad requests,
// issues one strobe, waits (bounded) for read data and reports completion.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_ren,
    output logic        o_dmem_wen,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_done,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause
);

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        is_load_q, is_load_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic        dmem_ren_q, dmem_ren_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic [3:0]  dmem_mask_q, dmem_mask_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        done_q, done_d;
    logic        trap_q, trap_d;
    logic [1:0]  trap_cause_q, trap_cause_d;

    logic        in_idle;
    logic [2:0]  align_funct3;
    logic [1:0]  align_addr_lo;
    logic [3:0]  align_mask;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;

    // In IDLE the aligner sees the live request; afterwards the latched one.
    assign in_idle       = (state_q == ST_IDLE);
    assign align_funct3  = in_idle ? i_funct3 : funct3_q;
    assign align_addr_lo = in_idle ? i_addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3    (align_funct3),
        .addr_lo   (align_addr_lo),
        .wdata     (i_wdata),
        .rdata     (i_dmem_rdata),
        .mask      (align_mask),
        .wdata_rep (align_wdata),
        .rdata_ext (align_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        is_load_d    = is_load_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_mask_d  = dmem_mask_q;
        dmem_wdata_d = dmem_wdata_q;
        rdata_d      = rdata_q;
        trap_cause_d = trap_cause_q;
        dmem_ren_d   = 1'b0;
        dmem_wen_d   = 1'b0;
        rvalid_d     = 1'b0;
        done_d       = 1'b0;
        trap_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (is_illegal(i_load, i_store, i_funct3)) begin
                        trap_d       = 1'b1;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end else if (is_misaligned(i_funct3, i_addr[1:0])) begin
                        trap_d       = 1'b1;
                        trap_cause_d = CAUSE_MISALIGNED;
                    end else begin
                        funct3_d     = i_funct3;
                        addr_lo_d    = i_addr[1:0];
                        is_load_d    = i_load;
                        dmem_addr_d  = {i_addr[31:2], 2'b00};
                        dmem_mask_d  = align_mask;
                        dmem_wdata_d = align_wdata;
                        dmem_ren_d   = i_load;
                        dmem_wen_d   = i_store;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // ISSUE is the first cycle a read return can arrive, so it counts as one.
                cnt_d = 8'd1;
                if (!is_load_q) begin
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (i_dmem_rvalid) begin
                    rdata_d  = align_rdata;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (i_dmem_rvalid) begin
                    rdata_d  = align_rdata;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end else if (cnt_d == TIMEOUT_CNT) begin
                    trap_d       = 1'b1;
                    trap_cause_d = CAUSE_TIMEOUT;
                    state_d      = ST_IDLE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            is_load_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_ren_q   <= 1'b0;
            dmem_wen_q   <= 1'b0;
            dmem_mask_q  <= '0;
            dmem_wdata_q <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            done_q       <= 1'b0;
            trap_q       <= 1'b0;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            is_load_q    <= is_load_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_ren_q   <= dmem_ren_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_mask_q  <= dmem_mask_d;
            dmem_wdata_q <= dmem_wdata_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            done_q       <= done_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign o_ready      = in_idle;
    assign o_dmem_addr  = dmem_addr_q;
    assign o_dmem_ren   = dmem_ren_q;
    assign o_dmem_wen   = dmem_wen_q;
    assign o_dmem_mask  = dmem_mask_q;
    assign o_dmem_wdata = dmem_wdata_q;
    assign o_rdata      = rdata_q;
    assign o_rvalid     = rvalid_q;
    assign o_done       = done_q;
    assign o_trap       = trap_q;
    assign o_trap_cause = trap_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset and
// stale-return sequences, then randomized requests against a behavioural model.
module tb_load_store_unit;

    localparam int TO    = 4;
    localparam int MAXK  = 40;
    localparam int NRAND = 150;

    localparam int K_DONE = 0;
    localparam int K_LOAD = 1;
    localparam int K_TRAP = 2;
    localparam int K_TMO  = 3;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } stim_t;

    typedef struct {
        int          kind;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  cause;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_ren;
    logic        o_dmem_wen;
    logic [3:0]  o_dmem_mask;
    logic [31:0] o_dmem_wdata;
    logic [31:0] i_dmem_rdata;
    logic        i_dmem_rvalid;
    logic [31:0] o_rdata;
    logic        o_rvalid;
    logic        o_done;
    logic        o_trap;
    logic [1:0]  o_trap_cause;

    int          checks;
    int          failures;
    logic [31:0] last_rdata;
    logic [1:0]  last_cause;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_load        (i_load),
        .i_store       (i_store),
        .i_funct3      (i_funct3),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_ren    (o_dmem_ren),
        .o_dmem_wen    (o_dmem_wen),
        .o_dmem_mask   (o_dmem_mask),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_rdata  (i_dmem_rdata),
        .i_dmem_rvalid (i_dmem_rvalid),
        .o_rdata       (o_rdata),
        .o_rvalid      (o_rvalid),
        .o_done        (o_done),
        .o_trap        (o_trap),
        .o_trap_cause  (o_trap_cause)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=time_limit required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL txn%0d %s actual=0x%08h required=0x%08h", id, name, act, exp);
        end
    endtask

    // Reference model: byte count, lane offset and extension from the ISA rules.
    function automatic exp_t model(input stim_t s);
        exp_t   e;
        int     nb;
        int     off;
        longint v;
        longint full;
        logic   illegal;
        logic   mis;
        e.kind  = K_DONE;
        e.mask  = '0;
        e.wdata = '0;
        e.rdata = '0;
        e.cause = 2'd0;
        nb      = 1 << s.f3[1:0];
        off     = int'(s.addr[1:0]);
        illegal = (s.ld == s.st) || (s.st && s.f3 > 3'd2) ||
                  (s.ld && (s.f3 == 3'd3 || s.f3 >= 3'd6));
        mis     = (s.addr % nb) != 0;
        if (illegal) begin
            e.kind  = K_TRAP;
            e.cause = 2'd2;
        end else if (mis) begin
            e.kind  = K_TRAP;
            e.cause = 2'd1;
        end else begin
            e.mask = 4'(((1 << nb) - 1) << off);
            for (int i = 0; i < 4; i++)
                e.wdata[8*i +: 8] = 8'(s.wdata >> (8 * (i % nb)));
            full = 64'd1 << (8 * nb);
            v    = longint'(s.rdata >> (8 * off));
            v    = v % full;
            if (!s.f3[2] && v >= full / 2)
                v = v - full;
            e.rdata = v[31:0];
            if (s.st) begin
                e.kind = K_DONE;
            end else if (s.delay <= TO - 1) begin
                e.kind = K_LOAD;
            end else begin
                e.kind  = K_TMO;
                e.cause = 2'd3;
            end
        end
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int    r;
        r    = int'($urandom_range(0, 19));
        s.ld = (r < 10);
        s.st = (r >= 10 && r < 19);
        if (r == 19) begin
            s.ld = 1'($urandom_range(0, 1));
            s.st = s.ld;
        end
        case ($urandom_range(0, 5))
            0:       s.f3 = 3'b000;
            1:       s.f3 = 3'b001;
            2:       s.f3 = 3'b010;
            3:       s.f3 = 3'b100;
            4:       s.f3 = 3'b101;
            default: s.f3 = 3'($urandom_range(0, 7));
        endcase
        s.addr = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            s.addr[0] = 1'b0;
            if (s.f3[1:0] == 2'b10)
                s.addr[1] = 1'b0;
        end
        s.wdata = $urandom;
        s.rdata = $urandom;
        s.delay = int'($urandom_range(0, 5));
        return s;
    endfunction

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int delay, input int kind,
                                input logic [3:0] mask, input logic [31:0] ewdata,
                                input logic [31:0] erdata, input logic [1:0] cause);
        vec_t v;
        v.s.ld    = ld;
        v.s.st    = st;
        v.s.f3    = f3;
        v.s.addr  = addr;
        v.s.wdata = wdata;
        v.s.rdata = rdata;
        v.s.delay = delay;
        v.e.kind  = kind;
        v.e.mask  = mask;
        v.e.wdata = ewdata;
        v.e.rdata = erdata;
        v.e.cause = cause;
        return v;
    endfunction

    // Called at a negedge with the DUT ready; returns at the negedge where it is ready again.
    task automatic run_txn(input stim_t s, input exp_t e, input int id);
        int          ready_k, rv_cnt, dn_cnt, tr_cnt, rv_k, dn_k, tr_k;
        int          ren_cnt, wen_cnt, strobe_k, exp_ready, exp_pk, act_pk;
        logic [31:0] st_addr, st_wdata, exp_pulses, exp_strobes;
        logic [3:0]  st_mask;
        ready_k = -1; rv_cnt = 0; dn_cnt = 0; tr_cnt = 0; rv_k = -1; dn_k = -1; tr_k = -1;
        ren_cnt = 0; wen_cnt = 0; strobe_k = -1;
        st_addr = '0; st_wdata = '0; st_mask = '0;
        i_valid       = 1'b1;
        i_load        = s.ld;
        i_store       = s.st;
        i_funct3      = s.f3;
        i_addr        = s.addr;
        i_wdata       = s.wdata;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = ~s.rdata;
        for (int k = 1; k <= MAXK && ready_k < 0; k++) begin
            @(negedge i_clk);
            if (o_rvalid) begin rv_cnt++; if (rv_k < 0) rv_k = k; end
            if (o_done)   begin dn_cnt++; if (dn_k < 0) dn_k = k; end
            if (o_trap)   begin tr_cnt++; if (tr_k < 0) tr_k = k; end
            if (o_dmem_ren || o_dmem_wen) begin
                strobe_k = k;
                st_addr  = o_dmem_addr;
                st_mask  = o_dmem_mask;
                st_wdata = o_dmem_wdata;
            end
            ren_cnt += int'(o_dmem_ren);
            wen_cnt += int'(o_dmem_wen);
            if (o_ready) ready_k = k;
            i_valid       = 1'b0;
            i_dmem_rvalid = s.ld && (k == 1 + s.delay);
            i_dmem_rdata  = (k == 1 + s.delay) ? s.rdata : ~s.rdata;
        end
        i_dmem_rvalid = 1'b0;

        case (e.kind)
            K_DONE:  begin exp_ready = 3;            exp_pk = 2;            exp_pulses = 32'h0000_0100; exp_strobes = 32'h01; act_pk = dn_k; end
            K_LOAD:  begin exp_ready = 3 + s.delay;  exp_pk = 2 + s.delay;  exp_pulses = 32'h0001_0000; exp_strobes = 32'h10; act_pk = rv_k; end
            K_TMO:   begin exp_ready = 1 + TO;       exp_pk = 1 + TO;       exp_pulses = 32'h0000_0001; exp_strobes = 32'h10; act_pk = tr_k; end
            default: begin exp_ready = 1;            exp_pk = 1;            exp_pulses = 32'h0000_0001; exp_strobes = 32'h00; act_pk = tr_k; end
        endcase

        $display("txn %0d ld=%0b st=%0b f3=%03b addr=%08h kind=%0d ready_k=%0d rdata=%08h cause=%0d",
                 id, s.ld, s.st, s.f3, s.addr, e.kind, ready_k, o_rdata, o_trap_cause);

        check("ready_cycle", id, ready_k, exp_ready);
        check("pulse_counts", id, (rv_cnt << 16) | (dn_cnt << 8) | tr_cnt, exp_pulses);
        check("pulse_cycle", id, act_pk, exp_pk);
        check("strobe_counts", id, (ren_cnt << 4) | wen_cnt, exp_strobes);
        if (e.kind != K_TRAP) begin
            check("strobe_cycle", id, strobe_k, 1);
            check("dmem_addr", id, st_addr, s.addr & 32'hFFFF_FFFC);
            check("dmem_mask", id, {28'b0, st_mask}, {28'b0, e.mask});
        end
        if (e.kind == K_DONE)
            check("dmem_wdata", id, st_wdata, e.wdata);
        if (e.kind == K_LOAD) begin
            check("load_rdata", id, o_rdata, e.rdata);
            last_rdata = e.rdata;
        end else begin
            check("rdata_held", id, o_rdata, last_rdata);
        end
        if (e.kind == K_TRAP || e.kind == K_TMO) begin
            check("trap_cause", id, {30'b0, o_trap_cause}, {30'b0, e.cause});
            last_cause = e.cause;
        end else begin
            check("cause_held", id, {30'b0, o_trap_cause}, {30'b0, last_cause});
        end
    endtask

    vec_t vecs[17];

    initial begin
        int stale_rv;
        int stale_busy;
        stim_t rs;

        checks        = 0;
        failures      = 0;
        last_rdata    = '0;
        last_cause    = 2'd0;
        i_rst         = 1'b1;
        i_valid       = 1'b0;
        i_load        = 1'b0;
        i_store       = 1'b0;
        i_funct3      = 3'b000;
        i_addr        = '0;
        i_wdata       = '0;
        i_dmem_rdata  = '0;
        i_dmem_rvalid = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        check("reset_ready", 0, {31'b0, o_ready}, 32'd1);
        check("reset_strobes_pulses", 0,
              {27'b0, o_rvalid, o_done, o_trap, o_dmem_ren, o_dmem_wen}, 32'd0);
        check("reset_data", 0, o_rdata | o_dmem_addr | o_dmem_wdata |
              {28'b0, o_dmem_mask} | {30'b0, o_trap_cause}, 32'd0);

        //          ld    st    f3      addr          wdata         rdata         dly kind    mask     ewdata        erdata        cause
        vecs[0]  = mk(1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        0, K_DONE, 4'b1111, 32'hDEAD_BEEF, 32'h0,        2'd0);
        vecs[1]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        0, K_DONE, 4'b1000, 32'hA5A5_A5A5, 32'h0,        2'd0);
        vecs[2]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0,        0, K_DONE, 4'b1100, 32'hBEEF_BEEF, 32'h0,        2'd0);
        vecs[3]  = mk(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0,         32'h1234_F0FF, 3, K_LOAD, 4'b0010, 32'h0,         32'hFFFF_FFF0, 2'd0);
        vecs[4]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0,         32'h1234_F0FF, 0, K_LOAD, 4'b0010, 32'h0,         32'h0000_00F0, 2'd0);
        vecs[5]  = mk(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'h1234_F0FF, 1, K_LOAD, 4'b1100, 32'h0,         32'h0000_1234, 2'd0);
        vecs[6]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h0,         32'h0000_8001, 2, K_LOAD, 4'b0011, 32'h0,         32'hFFFF_8001, 2'd0);
        vecs[7]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0,         32'hCAFE_F00D, 0, K_LOAD, 4'b1111, 32'h0,         32'hCAFE_F00D, 2'd0);
        vecs[8]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_2002, 32'h0,         32'h0,        0, K_TRAP, 4'b0000, 32'h0,         32'h0,        2'd1);
        vecs[9]  = mk(1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'h1,         32'h0,        0, K_TRAP, 4'b0000, 32'h0,         32'h0,        2'd2);
        vecs[10] = mk(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'h1,         32'h0,        0, K_TRAP, 4'b0000, 32'h0,         32'h0,        2'd2);
        vecs[11] = mk(1'b0, 1'b0, 3'b010, 32'h0000_1000, 32'h1,         32'h0,        0, K_TRAP, 4'b0000, 32'h0,         32'h0,        2'd2);
        vecs[12] = mk(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0,         32'h0,        0, K_TRAP, 4'b0000, 32'h0,         32'h0,        2'd2);
        vecs[13] = mk(1'b0, 1'b1, 3'b001, 32'h0000_1001, 32'h1,         32'h0,        0, K_TRAP, 4'b0000, 32'h0,         32'h0,        2'd1);
        vecs[14] = mk(1'b0, 1'b1, 3'b110, 32'h0000_1003, 32'h1,         32'h0,        0, K_TRAP, 4'b0000, 32'h0,         32'h0,        2'd2);
        vecs[15] = mk(1'b1, 1'b0, 3'b101, 32'h0000_2003, 32'h0,         32'h0,        0, K_TRAP, 4'b0000, 32'h0,         32'h0,        2'd1);
        vecs[16] = mk(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0,         32'h1234_F0FF, 4, K_TMO,  4'b0010, 32'h0,         32'h0,        2'd3);

        for (int i = 0; i < 17; i++)
            run_txn(vecs[i].s, vecs[i].e, i + 1);

        // Stale read returns after the timeout must be ignored in IDLE.
        stale_rv   = 0;
        stale_busy = 0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h1234_5678;
        repeat (3) begin
            @(negedge i_clk);
            stale_rv   += int'(o_rvalid);
            stale_busy += int'(!o_ready);
        end
        i_dmem_rvalid = 1'b0;
        check("stale_rvalid", 100, stale_rv, 0);
        check("stale_ready", 100, stale_busy, 0);
        check("stale_rdata", 100, o_rdata, last_rdata);

        // Reset while a load sits in WAIT aborts it silently.
        i_valid  = 1'b1;
        i_load   = 1'b1;
        i_store  = 1'b0;
        i_funct3 = 3'b010;
        i_addr   = 32'h0000_3000;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("wait_busy", 101, {31'b0, o_ready}, 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midrst_ready", 101, {31'b0, o_ready}, 32'd1);
        check("midrst_pulses", 101,
              {27'b0, o_rvalid, o_done, o_trap, o_dmem_ren, o_dmem_wen}, 32'd0);
        check("midrst_state", 101, o_rdata | o_dmem_addr | {30'b0, o_trap_cause}, 32'd0);
        stale_rv = 0;
        i_dmem_rvalid = 1'b1;
        repeat (2) begin
            @(negedge i_clk);
            stale_rv += int'(o_rvalid) + int'(o_trap);
        end
        i_dmem_rvalid = 1'b0;
        check("midrst_stale", 101, stale_rv, 0);
        last_rdata = '0;
        last_cause = 2'd0;

        for (int i = 0; i < NRAND; i++) begin
            rs = rand_stim();
            run_txn(rs, model(rs), 200 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
